// File: rtl/ctrl_word_sequencer.sv
`default_nettype none
// ============================================================================
// Module      : ctrl_word_sequencer
// Description : Reads precomputed control words from the instruction BRAM and
//               drives them onto the LUD datapath control bus. Each stored
//               word is {rep, ctrl}. The ctrl part is held for 1+rep cycles.
//               A word with ctrl[0] set, or the last programmed word, ends
//               the run.
// Ports       : CLK_100     - system clock, rising edge
//               RST         - asynchronous active-high reset
//               start       - run request, sampled only while idle
//               prog_len    - number of words to issue (latched on start)
//               abort       - stop the run at the next edge, no done pulse
//               imem_addr   - instruction BRAM address
//               imem_en     - instruction BRAM read enable (1-cycle latency)
//               imem_dout   - instruction BRAM read data {rep, ctrl}
//               CTRL_Signal - registered control word (0 = NOP)
//               busy        - high from start acceptance until run end
//               done        - one-cycle pulse on normal completion
//               issued_cnt  - words whose hold has completed in this run
// Revision    : 1.0 - initial release
// ============================================================================
module ctrl_word_sequencer #(
    parameter int CTRL_WIDTH      = 72,
    parameter int IMEM_ADDR_WIDTH = 12,
    parameter int REP_WIDTH       = 8
) (
    input  logic                            CLK_100,
    input  logic                            RST,
    input  logic                            start,
    input  logic [IMEM_ADDR_WIDTH:0]        prog_len,
    input  logic                            abort,
    output logic [IMEM_ADDR_WIDTH-1:0]      imem_addr,
    output logic                            imem_en,
    input  logic [CTRL_WIDTH+REP_WIDTH-1:0] imem_dout,
    output logic [CTRL_WIDTH-1:0]           CTRL_Signal,
    output logic                            busy,
    output logic                            done,
    output logic [IMEM_ADDR_WIDTH:0]        issued_cnt
);

    localparam logic [1:0] c_idle  = 2'd0;
    localparam logic [1:0] c_fetch = 2'd1;
    localparam logic [1:0] c_run   = 2'd2;

    localparam logic [IMEM_ADDR_WIDTH:0]   c_cnt_zero = '0;
    localparam logic [IMEM_ADDR_WIDTH:0]   c_cnt_one  = 1;
    localparam logic [IMEM_ADDR_WIDTH:0]   c_cnt_two  = 2;
    localparam logic [IMEM_ADDR_WIDTH-1:0] c_addr_one = 1;
    localparam logic [REP_WIDTH-1:0]       c_rep_zero = '0;
    localparam logic [REP_WIDTH-1:0]       c_rep_one  = 1;

    logic [1:0]                 r_state;
    logic [IMEM_ADDR_WIDTH:0]   r_prog_len;
    logic [IMEM_ADDR_WIDTH:0]   r_issued_cnt;
    logic [REP_WIDTH-1:0]       r_hold;      // extra hold cycles still to go
    logic                       r_last;      // word on the bus ends the run
    logic                       r_first;     // no word has been loaded yet
    logic [IMEM_ADDR_WIDTH-1:0] r_imem_addr;
    logic                       r_imem_en;
    logic [CTRL_WIDTH-1:0]      r_ctrl;
    logic                       r_busy;
    logic                       r_done;

    logic [CTRL_WIDTH-1:0]      w_dout_ctrl;
    logic [REP_WIDTH-1:0]       w_dout_rep;
    logic [IMEM_ADDR_WIDTH:0]   w_load_idx;
    logic                       w_load_last;
    logic [IMEM_ADDR_WIDTH:0]   w_load_pf;
    logic                       w_load_pf_ok;
    logic [IMEM_ADDR_WIDTH:0]   w_hold_pf;
    logic                       w_hold_pf_ok;

    assign w_dout_ctrl = imem_dout[CTRL_WIDTH-1:0];
    assign w_dout_rep  = imem_dout[CTRL_WIDTH+REP_WIDTH-1:CTRL_WIDTH];

    // While word i is on the bus, r_issued_cnt == i. The word sitting on the
    // BRAM output is therefore i+1 (or 0 before the first load).
    assign w_load_idx  = r_first ? c_cnt_zero : (r_issued_cnt + c_cnt_one);
    assign w_load_last = w_dout_ctrl[0] || ((w_load_idx + c_cnt_one) == r_prog_len);

    // The BRAM must read word j+1 on the edge word j is loaded, so the read
    // for j+2 is enabled during the final hold cycle of word j. A word that
    // ends the run suppresses further reads so nothing beyond it is fetched.
    assign w_load_pf    = w_load_idx + c_cnt_two;
    assign w_load_pf_ok = !w_load_last && (w_load_pf < r_prog_len);
    assign w_hold_pf    = r_issued_cnt + c_cnt_two;
    assign w_hold_pf_ok = !r_last && (w_hold_pf < r_prog_len);

    always_ff @(posedge CLK_100 or posedge RST) begin
        if (RST) begin
            r_state      <= c_idle;
            r_prog_len   <= '0;
            r_issued_cnt <= '0;
            r_hold       <= '0;
            r_last       <= 1'b0;
            r_first      <= 1'b0;
            r_imem_addr  <= '0;
            r_imem_en    <= 1'b0;
            r_ctrl       <= '0;
            r_busy       <= 1'b0;
            r_done       <= 1'b0;
        end else begin
            r_done <= 1'b0;
            case (r_state)
                c_idle: begin
                    r_imem_en <= 1'b0;
                    if (start) begin
                        if (prog_len != c_cnt_zero) begin
                            r_prog_len   <= prog_len;
                            r_issued_cnt <= '0;
                            r_busy       <= 1'b1;
                            r_imem_addr  <= '0;
                            r_imem_en    <= 1'b1;
                            r_state      <= c_fetch;
                        end else begin
                            // Empty program completes at once without a run.
                            r_done <= 1'b1;
                        end
                    end
                end

                c_fetch: begin
                    if (abort) begin
                        r_ctrl    <= '0;
                        r_busy    <= 1'b0;
                        r_imem_en <= 1'b0;
                        r_state   <= c_idle;
                    end else begin
                        r_imem_addr <= c_addr_one;
                        r_imem_en   <= (r_prog_len > c_cnt_one);
                        r_hold      <= '0;
                        r_first     <= 1'b1;
                        r_state     <= c_run;
                    end
                end

                c_run: begin
                    if (abort) begin
                        r_ctrl    <= '0;
                        r_busy    <= 1'b0;
                        r_imem_en <= 1'b0;
                        r_state   <= c_idle;
                    end else if (r_hold != c_rep_zero) begin
                        r_hold <= r_hold - c_rep_one;
                        if (r_hold == c_rep_one) begin
                            r_imem_en   <= w_hold_pf_ok;
                            r_imem_addr <= w_hold_pf[IMEM_ADDR_WIDTH-1:0];
                        end else begin
                            r_imem_en <= 1'b0;
                        end
                    end else if (!r_first && r_last) begin
                        r_issued_cnt <= r_issued_cnt + c_cnt_one;
                        r_ctrl       <= '0;
                        r_busy       <= 1'b0;
                        r_done       <= 1'b1;
                        r_imem_en    <= 1'b0;
                        r_state      <= c_idle;
                    end else begin
                        if (!r_first) begin
                            r_issued_cnt <= r_issued_cnt + c_cnt_one;
                        end
                        r_first     <= 1'b0;
                        r_ctrl      <= w_dout_ctrl;
                        r_hold      <= w_dout_rep;
                        r_last      <= w_load_last;
                        r_imem_en   <= (w_dout_rep == c_rep_zero) && w_load_pf_ok;
                        r_imem_addr <= w_load_pf[IMEM_ADDR_WIDTH-1:0];
                    end
                end

                default: begin
                    r_ctrl    <= '0;
                    r_busy    <= 1'b0;
                    r_imem_en <= 1'b0;
                    r_state   <= c_idle;
                end
            endcase
        end
    end

    assign imem_addr   = r_imem_addr;
    assign imem_en     = r_imem_en;
    assign CTRL_Signal = r_ctrl;
    assign busy        = r_busy;
    assign done        = r_done;
    assign issued_cnt  = r_issued_cnt;

endmodule
`default_nettype wire
